// File: rtl/ad_ip_jesd204_tpl_adc_pn_scan.sv
// PN-sequence scan controller: walks every channel, forces the test PN sequence,
// waits for lock, checks a fixed error window and records pass/fail per channel.
// Optional PN_SCAN_ERR_COUNT_EN adds a saturating error-cycle counter.
module ad_ip_jesd204_tpl_adc_pn_scan #(
  parameter int         NUM_CHANNELS  = 1,
  parameter logic [3:0] PN_SEQ        = 4'h1,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         LOCK_TIMEOUT  = 256,
  parameter int         CHECK_CYCLES  = 1024
) (
  input  logic                            link_clk,
  input  logic                            adc_rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [NUM_CHANNELS*4-1:0]       pn_seq_sel_in,
  output logic [NUM_CHANNELS*4-1:0]       pn_seq_sel,
  input  logic [NUM_CHANNELS-1:0]         pn_err,
  input  logic [NUM_CHANNELS-1:0]         pn_oos,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(NUM_CHANNELS):0]   cur_channel,
  output logic [NUM_CHANNELS-1:0]         pass_mask,
  output logic [NUM_CHANNELS-1:0]         fail_mask,
  output logic [15:0]                     err_count
);

  localparam int KW   = $clog2(NUM_CHANNELS) + 1;
  localparam int MAX1 = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int MAXP = (MAX1 > CHECK_CYCLES) ? MAX1 : CHECK_CYCLES;
  localparam int CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST      = KW'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LOCK, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [CW-1:0] cnt;
  logic          fail_flag;
  logic          ch_err, ch_oos;
  logic          busy_nxt;
  logic          lock_timeout;

  // Channel mux by comparison so k may be wider than the channel index.
  always_comb begin
    ch_err = 1'b0;
    ch_oos = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (k == KW'(i)) begin
        ch_err = pn_err[i];
        ch_oos = pn_oos[i];
      end
    end
  end

  // Timeout fires once LOCK_TIMEOUT full cycles have elapsed without lock.
  assign lock_timeout = (state == S_LOCK) && ch_oos && (cnt == LOCK_LAST);

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_SETTLE;
        k_nxt     = '0;
      end
      S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_LOCK;
      S_LOCK: begin
        if (!ch_oos)          state_nxt = S_CHECK;
        else if (lock_timeout) state_nxt = S_NEXT;
      end
      S_CHECK: if (cnt == CHECK_LAST) state_nxt = S_NEXT;
      S_NEXT: begin
        if (k == K_LAST) state_nxt = S_DONE;
        else begin
          state_nxt = S_SETTLE;
          k_nxt     = k + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        k_nxt     = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        k_nxt     = '0;
      end
    endcase
    if (abort && state != S_IDLE && state != S_DONE) begin
      state_nxt = S_IDLE;
      k_nxt     = '0;
    end
  end

  assign busy_nxt = (state_nxt == S_SETTLE) || (state_nxt == S_LOCK) ||
                    (state_nxt == S_CHECK)  || (state_nxt == S_NEXT);

  always_ff @(posedge link_clk) begin
    if (adc_rst) begin
      state <= S_IDLE;
      k     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      cnt   <= (state_nxt != state || state == S_IDLE) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge link_clk) begin
    if (adc_rst) begin
      fail_flag <= 1'b0;
      pass_mask <= '0;
      fail_mask <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        pass_mask <= '0;
        fail_mask <= '0;
      end else if (state == S_NEXT && state_nxt != S_IDLE) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (k == KW'(i)) begin
            pass_mask[i] <= !fail_flag;
            fail_mask[i] <= fail_flag;
          end
        end
      end
      if (state_nxt == S_IDLE || state == S_NEXT)
        fail_flag <= 1'b0;
      else if ((state == S_CHECK && (ch_err || ch_oos)) || lock_timeout)
        fail_flag <= 1'b1;
    end
  end

  // Selection is computed from the next state so the override lines up with busy.
  always_ff @(posedge link_clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!adc_rst && busy_nxt && k_nxt == KW'(i))
        pn_seq_sel[i*4 +: 4] <= PN_SEQ;
      else
        pn_seq_sel[i*4 +: 4] <= pn_seq_sel_in[i*4 +: 4];
    end
  end

`ifdef PN_SCAN_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge link_clk) begin
    if (adc_rst)
      err_cnt_q <= '0;
    else if (state == S_IDLE && start)
      err_cnt_q <= '0;
    else if (state == S_CHECK && (ch_err || ch_oos) && err_cnt_q != 16'hFFFF)
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'd0;
`endif

  assign busy        = (state == S_SETTLE) || (state == S_LOCK) ||
                       (state == S_CHECK)  || (state == S_NEXT);
  assign done        = (state == S_DONE);
  assign cur_channel = k;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_scan.sv
// Bench for the PN scan controller: vector table of scan scenarios checked
// through a scoreboard queue, plus abort / restart / mid-scan reset sequences.
module tb_ad_ip_jesd204_tpl_adc_pn_scan;

  logic       link_clk = 1'b0;
  logic       adc_rst;
  logic       start, abort;
  logic [7:0] pn_seq_sel_in, pn_seq_sel;
  logic [1:0] pn_err, pn_oos;
  logic       busy, done;
  logic [1:0] cur_channel;
  logic [1:0] pass_mask, fail_mask;
  logic [15:0] err_count;

  always #5 link_clk = ~link_clk;

  ad_ip_jesd204_tpl_adc_pn_scan #(
    .NUM_CHANNELS(2), .PN_SEQ(4'h1), .SETTLE_CYCLES(4),
    .LOCK_TIMEOUT(8), .CHECK_CYCLES(16)
  ) dut (
    .link_clk(link_clk), .adc_rst(adc_rst), .start(start), .abort(abort),
    .pn_seq_sel_in(pn_seq_sel_in), .pn_seq_sel(pn_seq_sel),
    .pn_err(pn_err), .pn_oos(pn_oos), .busy(busy), .done(done),
    .cur_channel(cur_channel), .pass_mask(pass_mask), .fail_mask(fail_mask),
    .err_count(err_count)
  );

  typedef struct {
    int          done_cyc;
    logic [1:0]  pass;
    logic [1:0]  fail;
    logic [15:0] errc;
  } exp_t;

  typedef struct {
    logic [1:0]  oos;
    int          err_cyc;
    int          done_cyc;
    logic [1:0]  pass;
    logic [1:0]  fail;
    logic [15:0] errc;
  } vec_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

`ifdef PN_SCAN_ERR_COUNT_EN
  localparam logic [15:0] ONE_ERR = 16'd1;
`else
  localparam logic [15:0] ONE_ERR = 16'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one scan started at E0; abort_cyc==0 means the scan should complete.
  task automatic scan(input logic [1:0] oos, input int err_cyc,
                      input int abort_cyc, input int restart_cyc);
    int   exp_end;
    bit   seen_done = 0;
    int   busy_bad = 0;
    exp_t e;
    exp_end = (abort_cyc == 0) ? sb[0].done_cyc : abort_cyc + 1;
    pn_oos = oos;
    start  = 1'b1;
    @(posedge link_clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge link_clk);
      if (busy !== (c < exp_end)) busy_bad++;
      if (c == 2) chk("sel_ch0", {24'd0, pn_seq_sel}, 32'h31);
      if (c == 30 && exp_end > 30) begin
        chk("sel_ch1", {24'd0, pn_seq_sel}, 32'h13);
        chk("cur_ch1", {30'd0, cur_channel}, 32'd1);
      end
      if (abort_cyc != 0 && c == abort_cyc + 1) begin
        chk("abort_pass", {30'd0, pass_mask}, 32'h1);
        chk("abort_fail", {30'd0, fail_mask}, 32'h0);
        chk("abort_sel", {24'd0, pn_seq_sel}, {24'd0, pn_seq_sel_in});
        chk("abort_cur", {30'd0, cur_channel}, 32'd0);
      end
      if (done) begin
        if (seen_done || sb.size() == 0) begin
          chk("unexpected_done", c, 0);
        end else begin
          e = sb.pop_front();
          seen_done = 1;
          chk("done_cycle", c, e.done_cyc);
          chk("pass_mask", {30'd0, pass_mask}, {30'd0, e.pass});
          chk("fail_mask", {30'd0, fail_mask}, {30'd0, e.fail});
          chk("err_count", {16'd0, err_count}, {16'd0, e.errc});
        end
      end
      pn_err = {1'b0, (c == err_cyc)};
      abort  = (c == abort_cyc);
      start  = (c == restart_cyc);
    end
    chk("busy_window", busy_bad, 0);
    chk("done_seen", seen_done, abort_cyc == 0);
    chk("end_idle", {busy, done}, 2'b00);
    pn_oos = 2'b00;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{2'b00, 0, 45, 2'b11, 2'b00, 16'd0};
    vecs[1] = '{2'b10, 0, 37, 2'b01, 2'b10, 16'd0};
    vecs[2] = '{2'b00, 8, 45, 2'b10, 2'b01, ONE_ERR};
    vecs[3] = '{2'b11, 0, 29, 2'b00, 2'b11, 16'd0};

    adc_rst = 1'b1; start = 1'b0; abort = 1'b0;
    pn_err = 2'b00; pn_oos = 2'b00; pn_seq_sel_in = 8'h33;
    repeat (3) @(posedge link_clk);
    @(negedge link_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cur", {30'd0, cur_channel}, 0);
    chk("rst_masks", {pass_mask, fail_mask}, 0);
    chk("rst_err", {16'd0, err_count}, 0);
    chk("rst_sel", {24'd0, pn_seq_sel}, 32'h33);
    adc_rst = 1'b0;
    repeat (2) @(negedge link_clk);

    foreach (vecs[i]) begin
      sb.push_back('{vecs[i].done_cyc, vecs[i].pass, vecs[i].fail, vecs[i].errc});
      scan(vecs[i].oos, vecs[i].err_cyc, 0, 0);
    end

    // start pulsed mid-scan must not disturb timing
    sb.push_back('{45, 2'b11, 2'b00, 16'd0});
    scan(2'b00, 0, 0, 10);

    // abort during channel 1 CHECK
    scan(2'b00, 0, 30, 0);

    // reset asserted during channel 0 SETTLE
    start = 1'b1;
    @(posedge link_clk);
    #1 start = 1'b0;
    repeat (2) @(negedge link_clk);
    chk("pre_rst_busy", busy, 1);
    adc_rst = 1'b1;
    @(negedge link_clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cur", {30'd0, cur_channel}, 0);
    chk("mid_rst_masks", {pass_mask, fail_mask}, 0);
    chk("mid_rst_err", {16'd0, err_count}, 0);
    chk("mid_rst_sel", {24'd0, pn_seq_sel}, 32'h33);
    adc_rst = 1'b0;
    begin
      int dn = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge link_clk);
        if (done || busy) dn++;
      end
      chk("post_rst_quiet", dn, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
